// File: rtl/rv_issue_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rv_issue_pkg
// Brief    : Shared encodings for the RV32I/RV64I ALU issue controller:
//            opcode/funct constants, ALU operation and FSM state enums, and
//            the funct3 -> ALU operation mapping.
// Revision : 1.0  initial release
// ============================================================================
package rv_issue_pkg;

  // Major opcodes handled by the issue controller
  localparam logic [6:0] c_opc_op     = 7'b0110011;
  localparam logic [6:0] c_opc_op_imm = 7'b0010011;

  // funct3 encodings shared by OP and OP-IMM
  localparam logic [2:0] c_f3_add_sub = 3'b000;
  localparam logic [2:0] c_f3_sll     = 3'b001;
  localparam logic [2:0] c_f3_slt     = 3'b010;
  localparam logic [2:0] c_f3_sltu    = 3'b011;
  localparam logic [2:0] c_f3_xor     = 3'b100;
  localparam logic [2:0] c_f3_srl_sra = 3'b101;
  localparam logic [2:0] c_f3_or      = 3'b110;
  localparam logic [2:0] c_f3_and     = 3'b111;

  // funct7 encodings: base form and the "alternate" form (SUB/SRA)
  localparam logic [6:0] c_f7_base = 7'b0000000;
  localparam logic [6:0] c_f7_alt  = 7'b0100000;

  // RV64 shift-immediate upper field (funct6)
  localparam logic [5:0] c_f6_base = 6'b000000;
  localparam logic [5:0] c_f6_alt  = 6'b010000;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SLT  = 4'd6,
    ALU_SLTU = 4'd7,
    ALU_SRA  = 4'd8,
    ALU_SRL  = 4'd9
  } alu_op_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DECODE = 3'd1,
    ST_READ   = 3'd2,
    ST_EXEC   = 3'd3,
    ST_WB     = 3'd4
  } state_e;

  // Map funct3 (plus the alternate-form bit) to an ALU operation. The
  // alternate bit only matters for ADD/SUB and SRL/SRA; legality of the
  // combination is checked by the caller.
  function automatic alu_op_e f3_to_alu_op(input logic [2:0] f3, input logic alt);
    alu_op_e op;
    case (f3)
      c_f3_add_sub: op = alt ? ALU_SUB : ALU_ADD;
      c_f3_sll:     op = ALU_SLL;
      c_f3_slt:     op = ALU_SLT;
      c_f3_sltu:    op = ALU_SLTU;
      c_f3_xor:     op = ALU_XOR;
      c_f3_srl_sra: op = alt ? ALU_SRA : ALU_SRL;
      c_f3_or:      op = ALU_OR;
      default:      op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage : rv_issue_pkg
`default_nettype wire

// File: rtl/rv_alu_field_decode.sv
`default_nettype none
// ============================================================================
// Module   : rv_alu_field_decode
// Brief    : Combinational decode of an OP / OP-IMM instruction word into
//            ALU operation, immediate-select, immediate value and an
//            illegal-encoding flag.
// Revision : 1.0  initial release
// ============================================================================
module rv_alu_field_decode
  import rv_issue_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  output logic [3:0]      alu_op,
  output logic            is_imm,
  output logic [XLEN-1:0] imm,
  output logic            illegal
);

  logic [6:0]      w_opcode;
  logic [2:0]      w_f3;
  logic [6:0]      w_f7;
  logic [5:0]      w_f6;
  logic            w_sh_base;
  logic            w_sh_alt;
  logic [XLEN-1:0] w_shamt;
  logic [XLEN-1:0] w_imm_sext;
  logic            w_unused;

  assign w_opcode   = instr[6:0];
  assign w_f3       = instr[14:12];
  assign w_f7       = instr[31:25];
  assign w_f6       = instr[31:26];
  assign w_imm_sext = {{(XLEN-12){instr[31]}}, instr[31:20]};
  // Register specifiers are consumed by the controller, not here
  assign w_unused   = ^{instr[19:15], instr[11:7]};

  // Shift-immediate qualifiers: RV64 frees instr[25] for a 6-bit shamt
  always_comb begin
    if (XLEN == 64) begin
      w_sh_base = (w_f6 == c_f6_base);
      w_sh_alt  = (w_f6 == c_f6_alt);
      w_shamt   = XLEN'(instr[25:20]);
    end else begin
      w_sh_base = (w_f7 == c_f7_base);
      w_sh_alt  = (w_f7 == c_f7_alt);
      w_shamt   = XLEN'(instr[24:20]);
    end
  end

  // Classify the encoding and pick operation / second operand source
  always_comb begin
    alu_op  = ALU_ADD;
    is_imm  = 1'b0;
    imm     = w_imm_sext;
    illegal = 1'b0;
    case (w_opcode)
      c_opc_op: begin
        if (w_f7 == c_f7_base) begin
          alu_op = f3_to_alu_op(w_f3, 1'b0);
        end else if (w_f7 == c_f7_alt &&
                     (w_f3 == c_f3_add_sub || w_f3 == c_f3_srl_sra)) begin
          alu_op = f3_to_alu_op(w_f3, 1'b1);
        end else begin
          illegal = 1'b1;
        end
      end
      c_opc_op_imm: begin
        is_imm = 1'b1;
        if (w_f3 == c_f3_sll) begin
          imm     = w_shamt;
          alu_op  = ALU_SLL;
          illegal = !w_sh_base;
        end else if (w_f3 == c_f3_srl_sra) begin
          imm     = w_shamt;
          alu_op  = w_sh_alt ? ALU_SRA : ALU_SRL;
          illegal = !(w_sh_base || w_sh_alt);
        end else begin
          // funct3 000 is always ADDI: there is no immediate subtract
          alu_op = f3_to_alu_op(w_f3, 1'b0);
        end
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule : rv_alu_field_decode
`default_nettype wire

// File: rtl/rv_alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : rv_alu_issue_ctrl
// Brief    : Decode-and-issue controller for RV32I/RV64I integer ALU ops.
//            Accepts one instruction per handshake, reads the register file,
//            issues to a variable-latency ALU and writes the result back.
//            Flags illegal encodings, suppresses writes to x0 and keeps
//            cycle / retired-instruction counters.
// Revision : 1.0  initial release
// ============================================================================
module rv_alu_issue_ctrl
  import rv_issue_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int RF_ADDR_W = 5,
  parameter int CNT_W     = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 instr_valid,
  output logic                 instr_ready,
  input  logic [31:0]          instr,
  output logic [RF_ADDR_W-1:0] rf_rs1_addr,
  output logic [RF_ADDR_W-1:0] rf_rs2_addr,
  input  logic [XLEN-1:0]      rf_rs1_data,
  input  logic [XLEN-1:0]      rf_rs2_data,
  output logic                 alu_req,
  output logic [3:0]           alu_op,
  output logic [XLEN-1:0]      alu_a,
  output logic [XLEN-1:0]      alu_b,
  input  logic                 alu_done,
  input  logic [XLEN-1:0]      alu_result,
  output logic                 rf_we,
  output logic [RF_ADDR_W-1:0] rf_wr_addr,
  output logic [XLEN-1:0]      rf_wr_data,
  output logic                 illegal,
  output logic [CNT_W-1:0]     cycle_count,
  output logic [CNT_W-1:0]     instret_count
);

  state_e          r_state;
  logic [31:0]     r_instr;
  logic            r_is_imm;
  logic [XLEN-1:0] r_imm;

  logic [3:0]      w_alu_op;
  logic            w_is_imm;
  logic [XLEN-1:0] w_imm;
  logic            w_illegal;
  logic            w_rd_nonzero;

  // Decode always looks at the captured word; only used in DECODE
  rv_alu_field_decode #(
    .XLEN (XLEN)
  ) u_decode (
    .instr   (r_instr),
    .alu_op  (w_alu_op),
    .is_imm  (w_is_imm),
    .imm     (w_imm),
    .illegal (w_illegal)
  );

  // x0 suppression uses the architectural rd field, independent of RF_ADDR_W
  assign w_rd_nonzero = (r_instr[11:7] != 5'd0);

  // Issue FSM with registered outputs and performance counters
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_instr       <= '0;
      r_is_imm      <= 1'b0;
      r_imm         <= '0;
      instr_ready   <= 1'b0;
      rf_rs1_addr   <= '0;
      rf_rs2_addr   <= '0;
      alu_req       <= 1'b0;
      alu_op        <= '0;
      alu_a         <= '0;
      alu_b         <= '0;
      rf_we         <= 1'b0;
      rf_wr_addr    <= '0;
      rf_wr_data    <= '0;
      illegal       <= 1'b0;
      cycle_count   <= '0;
      instret_count <= '0;
    end else begin
      cycle_count <= cycle_count + CNT_W'(1);
      // Single-cycle pulses default low
      illegal     <= 1'b0;
      rf_we       <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          instr_ready <= 1'b1;
          if (instr_valid && instr_ready) begin
            r_instr     <= instr;
            instr_ready <= 1'b0;
            r_state     <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          rf_rs1_addr <= RF_ADDR_W'(r_instr[19:15]);
          rf_rs2_addr <= RF_ADDR_W'(r_instr[24:20]);
          rf_wr_addr  <= RF_ADDR_W'(r_instr[11:7]);
          alu_op      <= w_alu_op;
          r_is_imm    <= w_is_imm;
          r_imm       <= w_imm;
          if (w_illegal) begin
            illegal     <= 1'b1;
            instr_ready <= 1'b1;
            r_state     <= ST_IDLE;
          end else begin
            r_state <= ST_READ;
          end
        end
        ST_READ: begin
          alu_a   <= rf_rs1_data;
          alu_b   <= r_is_imm ? r_imm : rf_rs2_data;
          alu_req <= 1'b1;
          r_state <= ST_EXEC;
        end
        ST_EXEC: begin
          if (alu_done) begin
            rf_wr_data <= alu_result;
            alu_req    <= 1'b0;
            rf_we      <= w_rd_nonzero;
            r_state    <= ST_WB;
          end
        end
        ST_WB: begin
          instret_count <= instret_count + CNT_W'(1);
          instr_ready   <= 1'b1;
          r_state       <= ST_IDLE;
        end
        default: begin
          instr_ready <= 1'b0;
          alu_req     <= 1'b0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule : rv_alu_issue_ctrl
`default_nettype wire

// File: doc/rv_alu_issue_ctrl.md
# rv_alu_issue_ctrl

Parametrised decode-and-issue controller for RV32I/RV64I integer ALU instructions (OP and OP-IMM classes). Sits between instruction fetch and the register file / ALU. Accepts one instruction per valid/ready handshake, reads source registers, issues operands to a variable-latency ALU, and writes the result back. Adds illegal-instruction detection, rd=x0 suppression, and cycle/retired-instruction counters.

## Interface
- XLEN, 32: datapath width; legal values 32 or 64.
- RF_ADDR_W, 5: register-file address width.
- CNT_W, 32: width of both performance counters.
- clk  in  1  clock.
- rst  in  1  reset; rst, synchronous, active-high; clock clk.
- instr_valid  in  1  fetch presents an instruction.
- instr_ready  out  1  block can accept an instruction.
- instr  in  32  instruction word.
- rf_rs1_addr, rf_rs2_addr  out  RF_ADDR_W  source register addresses.
- rf_rs1_data, rf_rs2_data  in  XLEN  source data; valid in the READ cycle.
- alu_req  out  1  operands valid; held until accepted.
- alu_op  out  4  ALU operation code.
- alu_a, alu_b  out  XLEN  operands.
- alu_done  in  1  result valid; sampled only while alu_req=1.
- alu_result  in  XLEN  ALU result.
- rf_we  out  1  write strobe, one-cycle pulse.
- rf_wr_addr  out  RF_ADDR_W  destination register.
- rf_wr_data  out  XLEN  write data.
- illegal  out  1  one-cycle pulse for an unsupported encoding.
- cycle_count, instret_count  out  CNT_W  performance counters.

## Operation
- States: IDLE, DECODE, READ, EXEC, WB.
- IDLE: instr_ready=1. On instr_valid&&instr_ready, capture instr and go to DECODE.
- DECODE:
  - Drive rs1/rs2/rd from instr[19:15], [24:20], [11:7]; zero-extend or truncate to RF_ADDR_W.
  - Compute alu_op and illegal.
  - Illegal: pulse illegal next cycle, return to IDLE, no write, no instret increment. Otherwise go to READ.
- alu_op encoding: ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLL=5, SLT=6, SLTU=7, SRA=8, SRL=9.
- Legal OP (opcode 0110011):
  - funct7=0000000 for any funct3.
  - funct7=0100000 only with funct3 000 (SUB) or 101 (SRA).
  - Any other funct7 is illegal (including M-extension funct7=0000001).
- Legal OP-IMM (opcode 0010011):
  - Immediate = instr[31:20] sign-extended to XLEN.
  - Shifts for XLEN=32: shamt=instr[24:20]; funct7 must be 0000000 (SLLI/SRLI) or 0100000 (SRAI).
  - Shifts for XLEN=64: shamt=instr[25:20]; funct6=instr[31:26] is checked the same way.
  - No SUBI: funct3 000 is always ADDI.
- Any other opcode is illegal.
- READ: at the end of the cycle, alu_a<=rf_rs1_data; alu_b<=rf_rs2_data (OP) or the immediate (OP-IMM). Go to EXEC.
- EXEC:
  - alu_req=1; alu_op, alu_a and alu_b are held stable.
  - On alu_done, latch alu_result into rf_wr_data and go to WB.
  - No timeout.
- WB:
  - rf_we=1 for exactly one cycle, unless rd==0 (rf_we stays 0).
  - instret_count increments in either case.
  - Go to IDLE.
- cycle_count increments every non-reset cycle.
- Both counters wrap modulo 2^CNT_W.

## Timing
- Reset values: all outputs 0, including instr_ready, counters and every address/data output; state=IDLE.
- Reset mid-operation: the in-flight instruction is dropped; no rf_we, illegal or alu_req after the reset edge.
- instr_ready goes high in the first cycle after rst deasserts.
- Accept at edge 0 → DECODE cycle 1 → READ cycle 2 → EXEC cycle 3 → WB cycle 4 (when alu_done is high in cycle 3) → instr_ready high in cycle 5.
- Minimum 5 cycles per instruction; each cycle alu_done is late adds one cycle.
- Illegal path: illegal pulse in cycle 2; instr_ready high in cycle 2.
- instr_valid while not ready is ignored; the instruction word is not sampled.
- alu_done while alu_req=0 is ignored.

## Structure
- Package rv_issue_pkg holds:
  - opcode constants OP/OP_IMM;
  - funct3 and funct7 constants;
  - alu_op enum (4-bit);
  - state enum.
- Sub-module rv_alu_field_decode: purely combinational; instr → alu_op, is_imm, imm (XLEN), illegal; parametrised by XLEN. The controller FSM instantiates it in DECODE.

## Test plan
- ADD 0x002081B3 with x1=5, x2=7, alu_done in the EXEC cycle → alu_op=0, a=5, b=7; rf_we in cycle 4 with addr 3, data 12; instret=1.
- SUB 0x402081B3 → alu_op=1. ADDI 0xFFF08293 → alu_op=0, alu_b=0xFFFFFFFF, rf_wr_addr=5.
- SRAI 0x4040D313 → alu_op=8, alu_b=4. Then 0x022081B3 (MUL) → illegal pulse in cycle 2; no alu_req, no rf_we; instret unchanged.
- ADD to x0 0x00208033 → alu_req issued; rf_we stays 0; instret increments.
- alu_done delayed 3 cycles → alu_req and operands stable for 4 cycles; WB in cycle 7; instr_valid held high throughout is accepted only in IDLE.
- rst asserted during EXEC → next cycle all outputs 0 and counters 0, no rf_we; next instruction completes normally. Counter wrap with CNT_W=4: 16 cycles → cycle_count returns to 0.
